// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer.
// The init sequence is only consumed when LCD_INIT_EN is defined.
package lcd_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEnable,
        StHold,
        StExec,
        StPwrup,
        StInit
    } lcd_state_e;

    localparam int unsigned OnBit    = 31;
    localparam int unsigned StartBit = 10;
    localparam int unsigned RsBit    = 9;
    localparam int unsigned DataMsb  = 7;
    localparam int unsigned DataLsb  = 0;

    localparam int unsigned InitLen = 6;
    // Element 0 is issued first: 0x38 x3, display on, clear, entry mode.
    localparam logic [InitLen-1:0][7:0] InitSeq = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed phase; done_o is high while the count is zero.
module lcd_delay_cnt #(
    parameter int unsigned     Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: turns START edges on the LCD register into timed RS/DATA/EN cycles.
// Define LCD_INIT_EN to add the power-up wait and built-in initialisation sequence after reset.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 25,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_LONG_CYC  = 82000,
    parameter int unsigned T_PWRUP_CYC = 750000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] io_lcd_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int unsigned CntMax = (T_LONG_CYC > T_PWRUP_CYC) ? T_LONG_CYC : T_PWRUP_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] SetupLd = CntW'(T_SETUP_CYC - 1);
    localparam logic [CntW-1:0] EnLd    = CntW'(T_EN_CYC - 1);
    localparam logic [CntW-1:0] HoldLd  = CntW'(T_HOLD_CYC - 1);
    localparam logic [CntW-1:0] ExecLd  = CntW'(T_EXEC_CYC - 1);
    localparam logic [CntW-1:0] LongLd  = CntW'(T_LONG_CYC - 1);

`ifdef LCD_INIT_EN
    localparam lcd_state_e      ResetState  = StPwrup;
    localparam logic [CntW-1:0] CntResetVal = CntW'(T_PWRUP_CYC - 1);
    localparam logic            BusyReset   = 1'b1;
`else
    localparam lcd_state_e      ResetState  = StIdle;
    localparam logic [CntW-1:0] CntResetVal = '0;
    localparam logic            BusyReset   = 1'b0;
`endif

    lcd_state_e      state_q, state_d, leave_state;
    logic            start_q, trigger, trig_used, leave_trig;
    logic [8:0]      new_cmd, cmd_q, cmd_d, pend_cmd_q, pend_cmd_d, leave_cmd;
    logic            pend_valid_q, pend_valid_d, leave_pend;
    logic            overrun_q, overrun_d;
    logic            en_q, en_d, busy_q, busy_d, on_q, on_d;
    logic            cnt_load, cnt_done, init_active;
    logic [CntW-1:0] cnt_val;
    logic            unused_bits;

`ifdef LCD_INIT_EN
    logic [2:0] idx_q, idx_d;
    logic       init_act_q, init_act_d;
    assign init_active = init_act_q;
`else
    assign init_active = 1'b0;
`endif

    assign trigger     = io_lcd_i[StartBit] & ~start_q;
    assign new_cmd     = {io_lcd_i[RsBit], io_lcd_i[DataMsb:DataLsb]};
    assign unused_bits = ^{io_lcd_i[30:11], io_lcd_i[8]};

    lcd_delay_cnt #(
        .Width   (CntW),
        .ResetVal(CntResetVal)
    ) u_delay_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .done_o    (cnt_done)
    );

    // Where to go once a command (or the whole init sequence) has finished.
    always_comb begin
        leave_state = StIdle;
        leave_cmd   = cmd_q;
        leave_pend  = pend_valid_q;
        leave_trig  = 1'b0;
        if (pend_valid_q) begin
            leave_state = StSetup;
            leave_cmd   = pend_cmd_q;
            leave_pend  = 1'b0;
        end else if (trigger) begin
            leave_state = StSetup;
            leave_cmd   = new_cmd;
            leave_trig  = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        pend_valid_d = pend_valid_q;
        pend_cmd_d   = pend_cmd_q;
        overrun_d    = overrun_q;
        trig_used    = 1'b0;
`ifdef LCD_INIT_EN
        idx_d      = idx_q;
        init_act_d = init_act_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d   = StSetup;
                    cmd_d     = new_cmd;
                    trig_used = 1'b1;
                end
            end
            StSetup:  if (cnt_done) state_d = StEnable;
            StEnable: if (cnt_done) state_d = StHold;
            StHold:   if (cnt_done) state_d = StExec;
            StExec: begin
                if (cnt_done) begin
                    if (init_active) begin
                        state_d = StInit;
                    end else begin
                        state_d      = leave_state;
                        cmd_d        = leave_cmd;
                        pend_valid_d = leave_pend;
                        trig_used    = leave_trig;
                    end
                end
            end
`ifdef LCD_INIT_EN
            StPwrup: if (cnt_done) state_d = StInit;
            StInit: begin
                if (idx_q == 3'(InitLen)) begin
                    init_act_d   = 1'b0;
                    state_d      = leave_state;
                    cmd_d        = leave_cmd;
                    pend_valid_d = leave_pend;
                    trig_used    = leave_trig;
                end else begin
                    state_d = StSetup;
                    cmd_d   = {1'b0, InitSeq[idx_q]};
                    idx_d   = idx_q + 3'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // A trigger the sequencer could not start goes to the one-entry buffer.
        if (trigger && !trig_used) begin
            if (pend_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_cmd_d   = new_cmd;
            end
        end

        cnt_load = (state_d != state_q);
        unique case (state_d)
            StSetup:  cnt_val = SetupLd;
            StEnable: cnt_val = EnLd;
            StHold:   cnt_val = HoldLd;
            StExec:   cnt_val = is_long_cmd(cmd_q[8], cmd_q[7:0]) ? LongLd : ExecLd;
            default:  cnt_val = '0;
        endcase
    end

    always_comb begin
        en_d   = (state_d == StEnable);
        busy_d = (state_d != StIdle);
        on_d   = io_lcd_i[OnBit];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ResetState;
            start_q      <= 1'b0;
            cmd_q        <= '0;
            pend_cmd_q   <= '0;
            pend_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= BusyReset;
            on_q         <= 1'b0;
`ifdef LCD_INIT_EN
            idx_q      <= '0;
            init_act_q <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            start_q      <= io_lcd_i[StartBit];
            cmd_q        <= cmd_d;
            pend_cmd_q   <= pend_cmd_d;
            pend_valid_q <= pend_valid_d;
            overrun_q    <= overrun_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            on_q         <= on_d;
`ifdef LCD_INIT_EN
            idx_q      <= idx_d;
            init_act_q <= init_act_d;
`endif
        end
    end

    assign lcd_on_o   = on_q;
    assign lcd_en_o   = en_q;
    assign lcd_rs_o   = cmd_q[8];
    assign lcd_data_o = cmd_q[7:0];
    assign lcd_rw_o   = 1'b0;
    assign busy_o     = busy_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed scenarios plus random command streams against a timeline model.
module tb_lcd_ctrl;

    localparam int unsigned SETUP = 2, EN = 4, HOLD = 2, EXEC = 10, LONG = 30, PWRUP = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_lcd = '0;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, overrun;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_SETUP_CYC(SETUP),
        .T_EN_CYC   (EN),
        .T_HOLD_CYC (HOLD),
        .T_EXEC_CYC (EXEC),
        .T_LONG_CYC (LONG),
        .T_PWRUP_CYC(PWRUP)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .io_lcd_i  (io_lcd),
        .lcd_on_o  (lcd_on),
        .lcd_en_o  (lcd_en),
        .lcd_rs_o  (lcd_rs),
        .lcd_rw_o  (lcd_rw),
        .lcd_data_o(lcd_data),
        .busy_o    (busy),
        .overrun_o (overrun)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed bus activity, sampled on the falling edge.
    int         rise_t[$];
    logic [8:0] rise_cmd[$];
    int         en_len[$];
    int         busy_fall[$];
    int         en_run = 0;
    logic       en_p = 1'b0, busy_p = 1'b0;

    always @(negedge clk) begin
        if (lcd_en) begin
            en_run = en_run + 1;
        end else begin
            if (en_p) en_len.push_back(en_run);
            en_run = 0;
        end
        if (lcd_en && !en_p) begin
            rise_t.push_back(cyc);
            rise_cmd.push_back({lcd_rs, lcd_data});
        end
        if (!busy && busy_p) busy_fall.push_back(cyc);
        en_p   = lcd_en;
        busy_p = busy;
    end

    // Reference model: a command occupies the bus from its start for a fixed duration;
    // one more may wait behind it, anything beyond that is dropped.
    int         exp_rise[$];
    logic [8:0] exp_cmd[$];
    int         exp_fall[$];
    int         chain_end = 0;
    int         last_start = -1;
    bit         had_work = 1'b0;
    logic       exp_ovr = 1'b0;

    function automatic int dur(input logic [8:0] c);
        int ex;
        ex = (c[8] == 1'b0 && c[7:0] >= 8'd1 && c[7:0] <= 8'd3) ? LONG : EXEC;
        return SETUP + EN + HOLD + ex;
    endfunction

    task automatic model_trig(input int t, input logic [8:0] c);
        int s;
        if (t >= chain_end) begin
            if (had_work && t > chain_end) exp_fall.push_back(chain_end);
            s = t;
        end else if (last_start <= t) begin
            s = chain_end;
        end else begin
            exp_ovr = 1'b1;
            return;
        end
        exp_rise.push_back(s + SETUP);
        exp_cmd.push_back(c);
        last_start = s;
        chain_end  = s + dur(c);
        had_work   = 1'b1;
    endtask

    task automatic clear_all();
        rise_t.delete(); rise_cmd.delete(); en_len.delete(); busy_fall.delete();
        exp_rise.delete(); exp_cmd.delete(); exp_fall.delete();
    endtask

    task automatic model_reset();
        clear_all();
        chain_end  = 0;
        last_start = -1;
        had_work   = 1'b0;
        exp_ovr    = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic rs, input logic [7:0] d);
        int guard = 0;
        while (cyc + 1 == last_start && guard < 4) begin
            step();
            guard++;
        end
        io_lcd = 32'h8000_0400 | {22'd0, rs, 1'b0, d};
        model_trig(cyc + 1, {rs, d});
        step();
        io_lcd[10] = 1'b0;
        step();
    endtask

    task automatic flush_check(input string tag);
        int guard = 0;
        while (cyc < chain_end + 3 && guard < 3000) begin
            step();
            guard++;
        end
        step();
        if (had_work) exp_fall.push_back(chain_end);
        had_work = 1'b0;
        chk({tag, "_nrise"}, rise_t.size(), exp_rise.size());
        for (int i = 0; i < rise_t.size() && i < exp_rise.size(); i++) begin
            chk({tag, "_rise_t"}, rise_t[i], exp_rise[i]);
            chk({tag, "_cmd"}, rise_cmd[i], exp_cmd[i]);
        end
        for (int i = 0; i < en_len.size(); i++) chk({tag, "_en_len"}, en_len[i], EN);
        chk({tag, "_nfall"}, busy_fall.size(), exp_fall.size());
        for (int i = 0; i < busy_fall.size() && i < exp_fall.size(); i++)
            chk({tag, "_busy_fall"}, busy_fall[i], exp_fall[i]);
        chk({tag, "_ovr"}, overrun, exp_ovr);
        chk({tag, "_rw"}, lcd_rw, 1'b0);
        clear_all();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         kind, p0, guard;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_en", lcd_en, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_on", lcd_on, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
`ifdef LCD_INIT_EN
        chk("rst_busy", busy, 1'b1);
`else
        chk("rst_busy", busy, 1'b0);
`endif
        rst_n = 1'b1;
        p0    = cyc;
        model_reset();

`ifdef LCD_INIT_EN
        begin
            logic [7:0] seq [6];
            int         gap;
            seq = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
            step();
            chk("init_busy_pwrup", busy, 1'b1);
            guard = 0;
            while (busy_fall.size() == 0 && guard < 600) begin
                step();
                guard++;
            end
            step();
            chk("init_nrise", rise_t.size(), 6);
            for (int i = 0; i < rise_t.size() && i < 6; i++) begin
                chk("init_cmd", rise_cmd[i], {1'b0, seq[i]});
                if (i == 0) begin
                    chk("init_first_rise_window",
                        (rise_t[0] >= p0 + PWRUP + SETUP) && (rise_t[0] <= p0 + PWRUP + SETUP + 2),
                        1'b1);
                end else begin
                    gap = rise_t[i] - rise_t[i-1];
                    chk("init_gap_window",
                        (gap >= dur({1'b0, seq[i-1]})) && (gap <= dur({1'b0, seq[i-1]}) + 2), 1'b1);
                end
            end
            for (int i = 0; i < en_len.size(); i++) chk("init_en_len", en_len[i], EN);
            chk("init_nfall", busy_fall.size(), 1);
            chk("init_busy_end", busy, 1'b0);
            model_reset();
            issue(1'b1, 8'h41);
            flush_check("post_init");
        end
`else
        // Single data write 0x41
        issue(1'b1, 8'h41);
        chk("on_high", lcd_on, 1'b1);
        flush_check("single");

        // Clear display takes the long wait
        issue(1'b0, 8'h01);
        flush_check("clear");

        // Second trigger during a transfer runs back-to-back
        issue(1'b1, 8'h41);
        step();
        issue(1'b1, 8'h42);
        flush_check("b2b");

        // Trigger on the exact cycle EXEC ends launches with no idle cycle
        issue(1'b1, 8'h55);
        guard = 0;
        while (cyc + 1 < chain_end && guard < 100) begin
            step();
            guard++;
        end
        issue(1'b0, 8'h0C);
        flush_check("direct");

        // Third trigger is dropped; overrun is sticky
        issue(1'b1, 8'h41);
        issue(1'b1, 8'h42);
        issue(1'b1, 8'h43);
        flush_check("overrun");
        issue(1'b1, 8'h20);
        flush_check("ovr_sticky");

        // ON pin follows bit 31
        io_lcd = 32'h0;
        step();
        step();
        chk("on_low", lcd_on, 1'b0);

        // Asynchronous reset while EN is high drops the pending command
        issue(1'b1, 8'h41);
        issue(1'b1, 8'h42);
        guard = 0;
        while (!lcd_en && guard < 50) begin
            step();
            guard++;
        end
        chk("en_seen_before_rst", lcd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("arst_en", lcd_en, 1'b0);
        chk("arst_rs", lcd_rs, 1'b0);
        chk("arst_data", lcd_data, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ovr", overrun, 1'b0);
        chk("arst_on", lcd_on, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        model_reset();
        repeat (60) step();
        chk("post_rst_nrise", rise_t.size(), 0);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ovr", overrun, 1'b0);
        clear_all();

        // Random command streams
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 20)) step();
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                issue(1'b0, 8'h01);
            end else if (kind == 1) begin
                d = 8'($urandom_range(4, 255));
                issue(1'b0, d);
            end else begin
                d = 8'($urandom_range(0, 255));
                issue(1'b1, d);
            end
        end
        flush_check("rand");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
